// File: rtl/ksa_seq_arbiter_if.sv
// Request/response bundle for the shared 16-bit Kogge-Stone sequencer.
// The master side is the issue logic and result consumer; the slave side is the arbiter.
interface ksa_seq_arbiter_if #(
  parameter int WORDS = 4
);
  localparam int W = 16 * WORDS;

  logic         req0_valid;
  logic         req0_ready;
  logic [W-1:0] req0_a;
  logic [W-1:0] req0_b;
  logic         req0_sub;
  logic         req1_valid;
  logic         req1_ready;
  logic [W-1:0] req1_a;
  logic [W-1:0] req1_b;
  logic         req1_sub;
  logic         rsp_valid;
  logic         rsp_ready;
  logic         rsp_id;
  logic [W-1:0] rsp_sum;
  logic         rsp_cout;
  logic         rsp_ovf;

  modport master (
    output req0_valid, req0_a, req0_b, req0_sub,
    output req1_valid, req1_a, req1_b, req1_sub,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_ovf
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_sub,
    input  req1_valid, req1_a, req1_b, req1_sub,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_ovf
  );
endinterface

// File: rtl/ksa_seq_arbiter.sv
// Round-robin arbiter that runs WORDS x 16-bit add/sub operations through one
// 16-bit Kogge-Stone adder, one chunk per cycle with a registered inter-chunk carry.
module ksa_seq_arbiter #(
  parameter int WORDS = 4
) (
  input  logic            clk,
  input  logic            rst,
  ksa_seq_arbiter_if.slave bus
);
  localparam int W  = 16 * WORDS;
  localparam int KW = $clog2(WORDS);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t        state;
  logic          last_grant;
  logic          grant;
  logic          grant_vld;
  logic [W-1:0]  a_reg;
  logic [W-1:0]  b_reg;
  logic          carry;
  logic [KW-1:0] k;
  logic [W-1:0]  sum_reg;
  logic          id_reg;
  logic          cout_reg;
  logic          ovf_reg;
  logic          valid_reg;
  logic [15:0]   a_chunk;
  logic [15:0]   b_chunk;
  logic [16:0]   ks_out;

  // Parallel-prefix 16-bit adder; cin is folded into bit 0's generate.
  function automatic logic [16:0] ksa16(input logic [15:0] x, input logic [15:0] y,
                                        input logic cin);
    logic [15:0] p0, g, p, gn, pn;
    p0   = x ^ y;
    g    = x & y;
    p    = p0;
    g[0] = g[0] | (p0[0] & cin);
    for (int d = 1; d < 16; d = d * 2) begin
      gn = g;
      pn = p;
      for (int i = d; i < 16; i++) begin
        gn[i] = g[i] | (p[i] & g[i-d]);
        pn[i] = p[i] & p[i-d];
      end
      g = gn;
      p = pn;
    end
    return {g[15], p0 ^ {g[14:0], cin}};
  endfunction

  always_comb begin
    grant_vld      = bus.req0_valid | bus.req1_valid;
    grant          = (bus.req0_valid && bus.req1_valid) ? ~last_grant : bus.req1_valid;
    bus.req0_ready = (state == IDLE) && grant_vld && !grant;
    bus.req1_ready = (state == IDLE) && grant_vld && grant;
    a_chunk        = a_reg[{k, 4'b0000} +: 16];
    b_chunk        = b_reg[{k, 4'b0000} +: 16];
    ks_out         = ksa16(a_chunk, b_chunk, carry);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      valid_reg  <= 1'b0;
      id_reg     <= 1'b0;
      sum_reg    <= '0;
      cout_reg   <= 1'b0;
      ovf_reg    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_vld) begin
            a_reg      <= grant ? bus.req1_a : bus.req0_a;
            b_reg      <= grant ? (bus.req1_sub ? ~bus.req1_b : bus.req1_b)
                                : (bus.req0_sub ? ~bus.req0_b : bus.req0_b);
            carry      <= grant ? bus.req1_sub : bus.req0_sub;
            id_reg     <= grant;
            last_grant <= grant;
            k          <= '0;
            state      <= CALC;
          end
        end
        // One chunk per cycle; the only inter-chunk carry path is the carry register.
        CALC: begin
          sum_reg[{k, 4'b0000} +: 16] <= ks_out[15:0];
          carry <= ks_out[16];
          k     <= k + 1'b1;
          if (k == KW'(WORDS - 1)) begin
            cout_reg  <= ks_out[16];
            ovf_reg   <= (a_reg[W-1] == b_reg[W-1]) && (ks_out[15] != a_reg[W-1]);
            valid_reg <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (bus.rsp_ready) begin
            valid_reg <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.rsp_valid = valid_reg;
  assign bus.rsp_id    = id_reg;
  assign bus.rsp_sum   = sum_reg;
  assign bus.rsp_cout  = cout_reg;
  assign bus.rsp_ovf   = ovf_reg;
endmodule

// File: doc/ksa_seq_arbiter.md
# ksa_seq_arbiter

Shares one 16-bit Kogge-Stone adder core between two requesters and sequences 64-bit (WORDS×16-bit) add/subtract operations through it, one 16-bit chunk per cycle with a registered carry. Requests are arbitrated round-robin and accepted with a valid/ready handshake. Results are returned on a single response channel tagged with the requester ID. The block sits between the integer-op issue logic and the adder datapath, so only one adder instance is needed per cluster.

## Interface
- WORDS, default 4: number of 16-bit chunks. Operand width is W = 16*WORDS. Legal values are 2..8.
- clk  input  1  clock. All state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- req0_valid / req1_valid  input  1  request pending from requester 0/1.
- req0_ready / req1_ready  output  1  grant; an operation is accepted when valid and ready are both high.
- req0_a, req0_b / req1_a, req1_b  input  W  operands.
- req0_sub / req1_sub  input  1  1 = compute a − b, 0 = compute a + b.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer accepts the result.
- rsp_id  output  1  requester that issued the result.
- rsp_sum  output  W  result, modulo 2^W.
- rsp_cout  output  1  carry out of bit W−1. For subtract, 1 means no borrow.
- rsp_ovf  output  1  two's-complement signed overflow.

## Operation
- The FSM has three states: IDLE, CALC, DONE. Reset state is IDLE.
- **IDLE**
  - Arbitration is round-robin on register last_grant, which resets to 1 so requester 0 wins first.
  - If only one requester is valid, it is granted.
  - If both are valid, the requester ≠ last_grant is granted.
  - reqN_ready = (state==IDLE) && grant==N. Ready is combinational; at most one ready is high.
  - On acceptance the block:
    - latches a;
    - latches b_eff = sub ? ~b : b;
    - loads carry register with cin = sub;
    - latches id;
    - sets last_grant = id and chunk index k = 0;
    - moves to CALC.
- **CALC**
  - Adder inputs are a[16k+15:16k], b_eff[16k+15:16k] and the carry register.
  - Each cycle the block writes the 16-bit sum into result chunk k, writes the adder carry-out into the carry register, and increments k.
  - When k == WORDS−1:
    - store the final carry as cout;
    - set ovf = (a[W−1] == b_eff[W−1]) && (sum[W−1] != a[W−1]);
    - move to DONE.
- **DONE**
  - rsp_valid = 1, and rsp_sum, rsp_cout, rsp_ovf, rsp_id are held stable.
  - When rsp_valid && rsp_ready, go to IDLE.
  - No request is accepted in the same cycle as the response handshake.
- **Arithmetic rules**
  - The sum wraps modulo 2^W.
  - Carry between chunks is only through the registered carry; there is no combinational path between chunks.
- Operands on req ports may change after acceptance without affecting the result.
- Reset outputs:
  - rsp_valid = 0, rsp_id = 0, rsp_sum = 0, rsp_cout = 0, rsp_ovf = 0;
  - req0_ready and req1_ready follow from state IDLE and the inputs.
- Reset mid-operation (CALC or DONE): the operation is discarded, state returns to IDLE, last_grant returns to 1, and no response is issued.

## Timing
- Acceptance edge is T0. CALC covers edges T1..TWORDS. rsp_valid rises after edge TWORDS, so the response is visible in cycle WORDS+1 after acceptance.
- Latency is WORDS+1 cycles from accept to rsp_valid. With WORDS=4, latency is 5.
- Minimum initiation interval is WORDS+2 cycles: accept, WORDS CALC cycles, a DONE cycle with rsp_ready high, then IDLE.
- rsp_ready low stalls in DONE indefinitely. Outputs are held and both ready signals are 0.
- The adder core is combinational within one cycle. Its critical path is bounded by one 16-bit Kogge-Stone plus the carry register setup.

## Test plan
- **Single add:** req0 sends a=0x0000_0000_0000_0003, b=0x0000_0000_0000_0004, sub=0.
  - Expect rsp_valid 5 cycles after accept, rsp_sum=0x7, rsp_cout=0, rsp_ovf=0, rsp_id=0.
- **Chunk carry chain:** req1 sends a=0x0000_FFFF_FFFF_FFFF, b=0x1.
  - Expect rsp_sum=0x0001_0000_0000_0000, rsp_cout=0, rsp_id=1.
  - Also a=0xFFFF_FFFF_FFFF_FFFF + 1: expect sum=0, cout=1, ovf=0.
- **Subtract and overflow:** 0x5 − 0x7.
  - Expect sum=0xFFFF_FFFF_FFFF_FFFE, cout=0, ovf=0.
  - 0x8000_0000_0000_0000 − 1: expect sum=0x7FFF_FFFF_FFFF_FFFF, cout=1, ovf=1.
  - 0x7FFF_FFFF_FFFF_FFFF + 1: expect ovf=1.
- **Round-robin:** after reset, hold both req valid for 4 operations.
  - Expect grant order 0,1,0,1, with exactly one ready high in each IDLE cycle and no ready outside IDLE.
- **Backpressure:** hold rsp_ready=0 for 10 cycles in DONE.
  - Expect rsp_* stable and both ready signals 0.
  - On release, the handshake happens and the next accept occurs the following cycle.
- **Reset mid-CALC:** assert rst at k=2.
  - Expect state IDLE and rsp_valid never rising for that operation.
  - Next, with both requesters valid, requester 0 is granted.
